packet_to_serial_framer: RTL and testbench

// - Sits between dma_memory_to_packet (output packet stream) and the UART transmitter (byte stream).
// - Buffers one complete packet and counts its bytes, then sends it framed: MAGIC, LEN_HI, LEN_LO, payload.
// - The host-side parser can then delimit packets on the raw serial line.

---
 rtl/packet_to_serial_framer_pkg.sv | 16 +
 rtl/packet_to_serial_framer_if.sv | 24 ++
 rtl/packet_to_serial_framer_buffer.sv | 21 ++
 rtl/packet_to_serial_framer.sv | 153 +++++++++++++++
 tb/tb_packet_to_serial_framer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_to_serial_framer_pkg.sv
// Shared definitions for the packet-to-serial framer and the host-side
// framing decoder: frame sequencing states and the frame start byte.
package packet_to_serial_framer_pkg;

  typedef enum logic [2:0] {
    FILL,
    DISCARD,
    HDR_MAGIC,
    HDR_LEN_HI,
    HDR_LEN_LO,
    DRAIN
  } frame_state_t;

  localparam logic [7:0] FRAME_MAGIC = 8'h51;

endpackage

// File: rtl/packet_to_serial_framer_if.sv
// Packet-in / serial-byte-out handshake bundle for packet_to_serial_framer.
// master : packet source and byte consumer (drives in_*, out_ready)
// slave  : the framer (drives in_ready, out_valid, out_data, busy, dropped)
interface packet_to_serial_framer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       dropped;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, busy, dropped
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, busy, dropped
  );
endinterface

// File: rtl/packet_to_serial_framer_buffer.sv
// Packet payload store: simple dual-port RAM, DEPTH x 8.
// Ports: clock; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out
// one cycle later (registered read, read every cycle). No reset on the array.
module packet_to_serial_framer_buffer #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/packet_to_serial_framer.sv
// Buffers one whole packet, then emits it as a frame: MAGIC, LEN_HI, LEN_LO,
// payload. Oversized packets are discarded and flagged with a dropped pulse.
// Ports: clock, clear_n (synchronous, active-low); bus (slave modport):
//   in_valid/in_data/in_last/in_ready  packet byte stream in
//   out_valid/out_data/out_ready       serial byte stream out
//   busy                               low only when idle with an empty buffer
//   dropped                            one-cycle pulse per discarded packet
module packet_to_serial_framer
  import packet_to_serial_framer_pkg::*;
#(
  parameter logic [7:0]  MAGIC       = FRAME_MAGIC,
  parameter int unsigned MAX_PAYLOAD = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                    clock,
  input  logic                    clear_n,
  packet_to_serial_framer_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(MAX_PAYLOAD);

  frame_state_t      state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [15:0]       len_q;
  logic              dropped_q;

  logic              full;
  logic              last_out;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  assign full     = (count_q == FULL_COUNT);
  assign last_out = (16'(rd_ptr_q) == (len_q - 16'd1));
  assign wr_en    = (state_q == FILL) && bus.in_valid && !full;

  packet_to_serial_framer_buffer #(
    .DEPTH  (MAX_PAYLOAD),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (count_q[ADDR_W-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // rd_addr steers the registered read so rd_data always holds buf[rd_ptr]
  // in DRAIN: buf[0] is prefetched in HDR_LEN_LO, a transfer fetches the
  // next byte, a stall re-reads the current one.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    rd_addr   = rd_ptr_q;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (full) state_d = bus.in_last ? FILL : DISCARD;
          else if (bus.in_last) state_d = HDR_MAGIC;
        end
      end
      DISCARD: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = FILL;
      end
      HDR_MAGIC: begin
        out_valid = 1'b1;
        out_data  = MAGIC;
        if (bus.out_ready) state_d = HDR_LEN_HI;
      end
      HDR_LEN_HI: begin
        out_valid = 1'b1;
        out_data  = len_q[15:8];
        if (bus.out_ready) state_d = HDR_LEN_LO;
      end
      HDR_LEN_LO: begin
        out_valid = 1'b1;
        out_data  = len_q[7:0];
        rd_addr   = '0;
        if (bus.out_ready) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = rd_data;
        if (bus.out_ready) begin
          rd_addr = rd_ptr_q + ADDR_W'(1);
          if (last_out) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= FILL;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dropped_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            if (full) begin
              // a last byte arriving on a full buffer is still an overflow
              if (bus.in_last) begin
                count_q   <= '0;
                dropped_q <= 1'b1;
              end
            end else begin
              count_q <= count_q + (ADDR_W+1)'(1);
              if (bus.in_last) len_q <= 16'(count_q) + 16'd1;
            end
          end
        end
        DISCARD: begin
          if (bus.in_valid && bus.in_last) begin
            count_q   <= '0;
            dropped_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (last_out) begin
              rd_ptr_q <= '0;
              count_q  <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.busy      = !((state_q == FILL) && (count_q == '0));
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_packet_to_serial_framer.sv
// Self-checking bench for packet_to_serial_framer (MAX_PAYLOAD=4): directed
// frames plus randomized packets/backpressure against a queue-based model.
module tb_packet_to_serial_framer;
  localparam int unsigned MP     = 4;
  localparam logic [7:0]  MAGIC  = 8'h51;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  packet_to_serial_framer_if bus ();

  packet_to_serial_framer #(
    .MAGIC       (MAGIC),
    .MAX_PAYLOAD (MP),
    .ADDR_W      (2)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];     // bytes of the frame still to be sent
  logic [7:0]  pkt[$];       // payload of the packet being received
  logic [7:0]  got_log[$];   // every byte observed transferring out
  bit          discarding  = 0;
  bit          drop_next   = 0;
  bit          after_reset = 0;
  bit          armed       = 0;
  bit          stalled_prev = 0;
  logic [7:0]  data_prev   = '0;
  int unsigned out_xfers   = 0;
  int unsigned drops_seen  = 0;
  int unsigned ready_mode  = 0;

  task automatic model_accept(input logic [7:0] d, input logic last);
    int n;
    if (discarding) begin
      if (last) begin
        discarding = 0;
        pkt.delete();
        drop_next = 1;
      end
    end else if (pkt.size() == MP) begin
      if (last) begin
        pkt.delete();
        drop_next = 1;
      end else begin
        discarding = 1;
      end
    end else begin
      pkt.push_back(d);
      if (last) begin
        n = pkt.size();
        exp_q.push_back(MAGIC);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        pkt.delete();
      end
    end
  endtask

  always @(negedge clock) begin
    bit in_fire, out_fire;
    if (armed) begin
      check_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check_eq("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() != 0) check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0]));
      else if (after_reset) check_eq("out_data_idle", 32'(bus.out_data), 32'(0));
      check_eq("busy", 32'(bus.busy), 32'(exp_q.size() != 0 || pkt.size() != 0 || discarding));
      check_eq("dropped", 32'(bus.dropped), 32'(drop_next));
      if (stalled_prev) check_eq("hold", 32'(bus.out_data), 32'(data_prev));
      if (bus.dropped) drops_seen++;
    end
    in_fire  = bus.in_valid && (exp_q.size() == 0);
    out_fire = (exp_q.size() != 0) && bus.out_ready;
    stalled_prev = (exp_q.size() != 0) && !bus.out_ready;
    data_prev    = bus.out_data;
    drop_next    = 0;
    if (!clear_n) begin
      exp_q.delete();
      pkt.delete();
      discarding   = 0;
      after_reset  = 1;
      stalled_prev = 0;
      armed        = 1;
    end else begin
      if (out_fire) begin
        got_log.push_back(bus.out_data);
        void'(exp_q.pop_front());
        out_xfers++;
      end
      if (in_fire) begin
        after_reset = 0;
        model_accept(bus.in_data, bus.in_last);
      end
    end
  end

  // ---------------- consumer backpressure ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic last);
    int unsigned n = 0;
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      @(negedge clock);
      ok = bus.in_ready;
      n++;
    end while (!ok && n < 200);
    if (!ok) check_eq("in_ready_timeout", 32'(ok), 32'(1));
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$]);
    foreach (p[i]) send_byte(p[i], i == p.size() - 1);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 500) check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string tag, input logic [7:0] ref_bytes[$]);
    check_eq({tag, "_len"}, 32'(got_log.size()), 32'(ref_bytes.size()));
    foreach (ref_bytes[i])
      if (i < got_log.size()) check_eq(tag, 32'(got_log[i]), 32'(ref_bytes[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] p[$];
    logic [7:0] e[$];
    int unsigned d0, x0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // three-byte packet, no backpressure
    got_log.delete();
    p = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(p);
    wait_idle();
    e = '{8'h51, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    check_log("frame3", e);

    // same packet, toggling ready
    got_log.delete();
    ready_mode = 1;
    send_pkt(p);
    wait_idle();
    check_log("frame3_bp", e);
    ready_mode = 0;

    // single byte
    got_log.delete();
    p = '{8'h7E};
    send_pkt(p);
    wait_idle();
    e = '{8'h51, 8'h00, 8'h01, 8'h7E};
    check_log("frame1", e);

    // oversized packet, then a short one
    got_log.delete();
    d0 = drops_seen;
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(p);
    wait_idle();
    check_eq("drop_count", 32'(drops_seen - d0), 32'(1));
    check_eq("drop_no_out", 32'(got_log.size()), 32'(0));
    p = '{8'h01, 8'h02};
    send_pkt(p);
    wait_idle();
    e = '{8'h51, 8'h00, 8'h02, 8'h01, 8'h02};
    check_log("after_drop", e);

    // exactly MAX_PAYLOAD bytes
    got_log.delete();
    d0 = drops_seen;
    p = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_pkt(p);
    wait_idle();
    e = '{8'h51, 8'h00, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13};
    check_log("frame_full", e);
    check_eq("full_no_drop", 32'(drops_seen - d0), 32'(0));

    // reset in DRAIN after two payload bytes
    x0 = out_xfers;
    send_pkt(p);
    for (int i = 0; i < 100 && out_xfers < x0 + 5; i++) begin
      @(posedge clock);
      #1;
    end
    check_eq("pre_reset_xfers", 32'(out_xfers - x0), 32'(5));
    clear_n = 1'b0;
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    @(negedge clock);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clock);
    #1;
    got_log.delete();
    p = '{8'h55};
    send_pkt(p);
    wait_idle();
    e = '{8'h51, 8'h00, 8'h01, 8'h55};
    check_log("after_reset", e);

    // randomized packets, lengths around the limit, random backpressure
    for (int k = 0; k < 40; k++) begin
      int unsigned len;
      ready_mode = $urandom_range(0, 2);
      len = $urandom_range(1, MP + 2);
      for (int j = 0; j < int'(len); j++) begin
        send_byte(8'($urandom), j == int'(len) - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
      end
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    ready_mode = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
